uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampled UART receiver in the slow UART clock domain.
- Deserialises rx_in frames (start, 8 data bits LSB-first, optional parity, stop) into a parallel word plus a one-cycle valid.
- Sits directly upstream of the cross-domain data synchroniser: data_out feeds its unsync bus, data_valid feeds its bus enable.
- data_out is held stable between frames so the destination domain can capture it safely.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and the edge counter.

Ports:
- clk  in  1  UART oversampling clock (prescale ticks per bit).
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idles high; externally synchronised.
- prescale  in  PRESCALE_WIDTH  clk cycles per bit; legal values 8, 16, 32.
- par_en  in  1  1 = parity bit present.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- data_out  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- par_err  out  1  one-cycle pulse: bad parity on the frame just ended.
- stop_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: data_out = 0, data_valid = 0, par_err = 0, stop_err = 0. The FSM goes to IDLE and all counters clear. Reset mid-frame aborts the frame with no pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on the first cycle rx_in = 0. edge_cnt starts at 0 in that cycle.
- Config latch: prescale, par_en and par_typ are latched on IDLE -> START. Changes mid-frame are ignored.
- Edge counter: edge_cnt runs 0..prescale-1 within each bit. bit_cnt advances when edge_cnt = prescale-1.
- Sampling:
  - Samples are taken at edge_cnt = h-1, h and h+1, where h = prescale>>1.
  - The bit value is the majority of the three samples.
  - The decision is available from edge_cnt = h+2 onward.
- START:
  - If the start bit decides 1, it is a glitch: return to IDLE at the end of that bit. No flags.
  - Otherwise go to DATA at edge_cnt = prescale-1.
- DATA:
  - DATA_WIDTH bits, LSB first, shifted into an internal register (not data_out).
  - After the last bit, go to PARITY if the latched par_en = 1, else go to STOP.
- PARITY:
  - expected = ^data for even parity, ~^data for odd parity.
  - Mismatch sets an internal par_fail.
- STOP: if the stop bit decides 0, set stop_fail.
- Frame end, in the cycle after STOP edge_cnt = prescale-1:
  - No failure: data_out <= shift register and data_valid = 1 for exactly one cycle.
  - par_fail and/or stop_fail: the matching err pulse(s) = 1 for one cycle; data_valid = 0 and data_out is unchanged.
  - Both errors may pulse together.
- After STOP the FSM is in IDLE. A low rx_in in that same cycle starts the next frame (back-to-back frames supported, 0-cycle gap).
- Latency: data_valid rises (1 + DATA_WIDTH + par_en + 1) × prescale cycles after the start-bit falling edge. For prescale 8 with parity that is 88 cycles.
- data_out holds its value until the next good frame. The downstream synchroniser relies on this stability.
- Illegal prescale (anything other than 8/16/32) is unsupported. The FSM must still return to IDLE and must not lock up.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE..STOP).
  - Prescale constants PRESC_8/16/32.
  - Parity type constants PAR_EVEN = 0, PAR_ODD = 1.
  - DATA_WIDTH default.
- One sub-module, uart_rx_sampler:
  - Contains the edge counter and the three-sample majority voter.
  - Outputs bit_done (edge_cnt = prescale-1) and sampled_bit.
  - Instantiated once in uart_rx.

Test Plan:
- Good frame, even parity: prescale=8, par_en=1, par_typ=0, frame 0xA5 with parity bit 0 -> data_out=0xA5, data_valid high one cycle 88 cycles after start edge, no errors.
- Glitch: rx_in low for 2 cycles then high, prescale=16 -> FSM back in IDLE, no valid/error pulses, data_out unchanged.
- Parity error: odd parity, 0x3C with parity bit 0 -> par_err one-cycle pulse, data_valid=0, data_out keeps its previous value.
- Stop error: prescale=32, par_en=0, 0x5A with stop bit 0 -> stop_err pulse, no data_valid.
- Back-to-back, no gap: prescale=32, par_en=0, 0x11 then 0x22 -> two data_valid pulses 320 cycles apart, data_out 0x11 then 0x22.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF, release, then send 0x81 -> outputs 0 during reset, single valid with 0x81 only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_PRESCALE_WIDTH = 6;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Two-out-of-three vote used to reject single-sample line noise.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-sample majority voter around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      active,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done,
    output logic                      sampled_bit
);

    localparam int unsigned PW = PRESCALE_WIDTH;

    logic [PW-1:0] edge_cnt_q, edge_cnt_d;
    logic [PW-1:0] half_c, last_c;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;
    logic          bit_q, bit_d;

    // Counter is 0 in the start-detect cycle, so the first active cycle is edge 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        bit_d      = bit_q;
        half_c     = prescale >> 1;
        last_c     = prescale - PW'(1);
        bit_done   = active && (edge_cnt_q == last_c);

        if (start) begin
            edge_cnt_d = PW'(1);
        end else if (!active || bit_done) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + PW'(1);
        end

        // Decision registers on h+1, so it is stable from h+2 to the bit end.
        if (active) begin
            if (edge_cnt_q == half_c - PW'(1)) s0_d = rx_in;
            if (edge_cnt_q == half_c)          s1_d = rx_in;
            if (edge_cnt_q == half_c + PW'(1)) bit_d = majority3(s0_q, s1_q, rx_in);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            bit_q      <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            bit_q      <= bit_d;
        end
    end

    assign sampled_bit = bit_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frames start/data/parity/stop into a held word plus status pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err
);

    localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_fail_q, par_fail_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;

    logic start_c, active_c, exp_par_c, stop_fail_c;
    logic bit_done, sampled_bit;

    assign start_c  = (state_q == IDLE) && !rx_in;
    assign active_c = (state_q != IDLE);

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .active      (active_c),
        .rx_in       (rx_in),
        .prescale    (presc_q),
        .bit_done    (bit_done),
        .sampled_bit (sampled_bit)
    );

    // Frame sequencing; every state leaves on bit_done so no state can stall.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_fail_d  = par_fail_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_d      = 1'b0;
        serr_d      = 1'b0;
        stop_fail_c = 1'b0;
        exp_par_c   = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                par_fail_d = 1'b0;
                if (!rx_in) begin
                    state_d   = START;
                    presc_d   = prescale;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                end
            end
            START: begin
                if (bit_done) state_d = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_fail_d = (sampled_bit != exp_par_c);
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    stop_fail_c = !sampled_bit;
                    perr_d      = par_fail_q;
                    serr_d      = stop_fail_c;
                    if (!par_fail_q && !stop_fail_c) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_fail_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_fail_q <= par_fail_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign par_err    = perr_q;
    assign stop_err   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level event model checked every cycle, plus literal pins.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data_out;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    typedef struct {
        int         at;
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_data;
    logic       ev_v, ev_pe, ev_se;
    int         valid_cnt = 0;
    int         perr_cnt = 0;
    int         serr_cnt = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .data_out   (data_out),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs per cycle: pulses only on scheduled frame-end cycles.
    always @(negedge clk) begin
        ev_v  = 1'b0;
        ev_pe = 1'b0;
        ev_se = 1'b0;
        if (!rst) begin
            exp_data = 8'h00;
        end else begin
            while (evq.size() > 0 && evq[0].at < cyc) begin
                check("event_slot", cyc, evq[0].at);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].at == cyc) begin
                ev    = evq.pop_front();
                ev_v  = ev.v;
                ev_pe = ev.pe;
                ev_se = ev.se;
                if (ev.v) exp_data = ev.d;
            end
        end
        check("data_valid", data_valid, ev_v);
        check("par_err", par_err, ev_pe);
        check("stop_err", stop_err, ev_se);
        check("data_out", data_out, exp_data);
        if (data_valid === 1'b1) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            valid_cnt++;
        end
        if (par_err === 1'b1) perr_cnt++;
        if (stop_err === 1'b1) serr_cnt++;
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; cut>0 abandons it after that many cycles with no expected result.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic par_bit, input logic stop_bit,
                              input int cut, output int t0);
        logic bits[$];
        ev_t  e;
        int   nb;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        nb       = bits.size();
        t0       = cyc;
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = ptyp;
        if (cut == 0) begin
            e.at = t0 + nb * p;
            e.pe = pen && (par_bit != (ptyp ? ~^d : ^d));
            e.se = !stop_bit;
            e.v  = !e.pe && !e.se;
            e.d  = d;
            evq.push_back(e);
        end
        for (int i = 0; i < nb * p; i++) begin
            if (cut != 0 && i == cut) break;
            rx_in = bits[i / p];
            @(posedge clk);
            #1;
            if (i == 0) begin
                prescale = (p == 8) ? 6'd16 : 6'd8;
                par_en   = ~pen;
                par_typ  = ~ptyp;
            end
        end
    endtask

    initial begin
        int t0, t1, t2, vc;
        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        #1 rst   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_pulses", {data_valid, par_err, stop_err}, 3'b000);
        rst = 1'b1;
        idle(10);

        // Good frame, even parity, prescale 8.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(5);
        check("a5_latency", last_valid_cyc - t0, 88);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid_cnt", valid_cnt, 1);

        // Two-cycle glitch at prescale 16.
        vc       = valid_cnt;
        prescale = 6'd16;
        rx_in    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        idle(40);
        check("glitch_no_valid", valid_cnt, vc);
        check("glitch_no_err", perr_cnt + serr_cnt, 0);
        check("glitch_data", data_out, 8'hA5);

        // Odd parity with wrong parity bit.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 0, t0);
        idle(5);
        check("perr_cnt", perr_cnt, 1);
        check("perr_data_held", data_out, 8'hA5);

        // Stop error, prescale 32, no parity.
        send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0, t0);
        idle(5);
        check("serr_cnt", serr_cnt, 1);
        check("serr_valid_cnt", valid_cnt, 1);

        // Parity and stop errors in the same frame.
        send_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, t0);
        idle(3);
        check("both_perr", perr_cnt, 2);
        check("both_serr", serr_cnt, 2);

        // Back-to-back frames with zero gap.
        send_frame(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, t1);
        send_frame(8'h22, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, t2);
        idle(5);
        check("b2b_gap", last_valid_cyc - prev_valid_cyc, 320);
        check("b2b_first_latency", prev_valid_cyc - t1, 320);
        check("b2b_data", data_out, 8'h22);
        check("b2b_valid_cnt", valid_cnt, 3);

        // Reset during data bit 3, then a clean frame.
        vc = valid_cnt;
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 8 + 4, t0);
        rst   = 1'b0;
        rx_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midreset_data", data_out, 8'h00);
        evq.delete();
        rst = 1'b1;
        idle(20);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, t0);
        idle(20);
        check("post_reset_data", data_out, 8'h81);
        check("post_reset_valid_cnt", valid_cnt - vc, 1);
        check("queue_drained", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
